// File: rtl/ser_pkg.sv
// ser_pkg: shared types and defaults for the serial bit feeder.
// The PARITY state value is always declared; it is only reachable when the
// feeder is built with SER_PARITY_EN defined.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: bit-index counter for one serialized word.
// Counts 0..WIDTH-1; clear has priority over enable. o_is_last flags the
// index of the final data bit.
module ser_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_is_last
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear restarts a word, enable advances one consumed bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count   = r_count;
  assign o_is_last = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: accepts parallel words on a valid/ready handshake and
// shifts them out MSB-first, one bit per unstalled clock, with no bubble
// between back-to-back words.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit per word.
//
// Handshake: a word transfers on a rising edge where i_in_valid && o_in_ready.
// o_in_ready is combinational: high in IDLE, and high in the cycle the final
// bit of a word sits on o_dout with i_stall low; low otherwise. The source must
// hold i_in_data stable until the transfer. o_dout_valid marks a live serial
// bit; a bit is consumed on an edge where o_dout_valid && !i_stall.
module serial_bit_feeder
  import ser_pkg::*;
#(
  parameter  int WIDTH = SER_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_stall,
  output logic             o_dout,
  output logic             o_dout_valid,
  output logic             o_word_done,
  output logic             o_busy,
  output ser_state_t       o_state,
  output logic [CNT_W-1:0] o_bit_count
);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             r_dout;
  logic             r_dout_valid;
  logic             w_dout_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_is_last;
  logic             w_load;
  logic             w_in_ready;
  logic             w_word_done;
`ifdef SER_PARITY_EN
  logic             r_parity;
  logic             w_parity_nxt;
`endif

  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .i_clk     (i_clock),
    .i_rst     (i_reset),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_count   (o_bit_count),
    .o_is_last (w_is_last)
  );

  // Next-state, shift-register, counter-control and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_in_ready  = 1'b0;
    w_word_done = 1'b0;
`ifdef SER_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      IDLE: begin
        // Stall never blocks acceptance while nothing is in flight.
        w_in_ready = 1'b1;
      end
      SHIFT: begin
        if (!i_stall) begin
          if (w_is_last) begin
            w_cnt_clr = 1'b1;
`ifdef SER_PARITY_EN
            // Last data bit consumed; the parity bit follows.
            w_state_nxt = PARITY;
            w_shift_nxt = r_shift << 1;
`else
            w_word_done = 1'b1;
            w_in_ready  = 1'b1;
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
`endif
          end else begin
            w_cnt_en    = 1'b1;
            w_shift_nxt = r_shift << 1;
          end
        end
      end
      PARITY: begin
`ifdef SER_PARITY_EN
        if (!i_stall) begin
          w_word_done = 1'b1;
          w_in_ready  = 1'b1;
          w_state_nxt = IDLE;
        end
`else
        w_state_nxt = IDLE;
        w_shift_nxt = '0;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_shift_nxt = '0;
      end
    endcase

    // A transfer overrides the end-of-word return to IDLE, so the next word
    // starts on the very next cycle.
    w_load = i_in_valid && w_in_ready;
    if (w_load) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = i_in_data;
      w_cnt_clr   = 1'b1;
`ifdef SER_PARITY_EN
      w_parity_nxt = ^i_in_data;
`endif
    end

`ifdef SER_PARITY_EN
    w_dout_nxt = (w_state_nxt == PARITY) ? w_parity_nxt : w_shift_nxt[WIDTH-1];
`else
    w_dout_nxt = w_shift_nxt[WIDTH-1];
`endif
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: shift word, registered serial bit and its valid.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_shift      <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_shift      <= w_shift_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= (w_state_nxt != IDLE);
    end
  end

`ifdef SER_PARITY_EN
  // Parity register: captured with the word so the PARITY cycle needs no
  // copy of the data.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_nxt;
    end
  end
`endif

  assign o_in_ready   = w_in_ready;
  assign o_word_done  = w_word_done;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_state      = r_state;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed scenarios plus randomized streaming for
// serial_bit_feeder. A queue of owed serial bits is the reference model.
module tb_serial_bit_feeder;
  import ser_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);
`ifdef SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             stall = 1'b0;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             word_done;
  logic             busy;
  ser_state_t       state;
  logic [CNT_W-1:0] bit_count;

  int checks = 0;
  int errors = 0;

  // Owed serial bits, oldest first: bit 1 = last bit of its word, bit 0 = value.
  logic [1:0] exp_q[$];
  logic       m_valid, m_dout, m_done, m_ready;

  serial_bit_feeder #(.WIDTH(WIDTH)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_stall      (stall),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .o_word_done  (word_done),
    .o_busy       (busy),
    .o_state      (state),
    .o_bit_count  (bit_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Serial bit k of a word (0 = MSB); index WIDTH is the even-parity bit.
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int k);
    if (k < WIDTH) return w[WIDTH-1-k];
    return ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      checks++;
      if ({dout, dout_valid, word_done, busy, in_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL sb_reset {dout,valid,done,busy,ready} got %b want 00001",
                 {dout, dout_valid, word_done, busy, in_ready});
      end
    end else begin
      m_valid = (exp_q.size() > 0);
      m_dout  = m_valid ? exp_q[0][0] : 1'b0;
      m_done  = m_valid && exp_q[0][1] && !stall;
      m_ready = !m_valid || m_done;
      checks++;
      if ({dout, dout_valid, word_done, busy, in_ready} !==
          {m_dout, m_valid, m_done, m_valid, m_ready}) begin
        errors++;
        $display("FAIL sb_stream t=%0t {dout,valid,done,busy,ready} got %b want %b",
                 $time, {dout, dout_valid, word_done, busy, in_ready},
                 {m_dout, m_valid, m_done, m_valid, m_ready});
      end
      if (m_valid && !stall) void'(exp_q.pop_front());
      if (in_valid && m_ready) begin
        for (int k = 0; k < NB; k++) exp_q.push_back({(k == NB - 1), exp_bit(in_data, k)});
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dout, dout_valid, word_done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values got %b want 0000", {dout, dout_valid, word_done, busy});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", in_ready);
    end
    tick();
    stall = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, dout_valid} !== 3'b100) begin
      errors++;
      $display("FAIL idle_stall_ready {ready,busy,valid} got %b want 100", {in_ready, busy, dout_valid});
    end
    tick();
    stall = 1'b0;
  endtask

  task automatic test_single_word(input logic [WIDTH-1:0] w);
    logic [3:0] want;
    tick();
    in_data = w; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_idle got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= NB + 1; k++) begin
      @(negedge clk);
      if (k <= NB) want = {exp_bit(w, k - 1), 1'b1, (k == NB), (k == NB)};
      else         want = 4'b0001;
      checks++;
      if ({dout, dout_valid, word_done, in_ready} !== want || busy !== (k <= NB)) begin
        errors++;
        $display("FAIL single_word w=%h cycle %0d {dout,valid,done,ready} got %b want %b busy %b",
                 w, k, {dout, dout_valid, word_done, in_ready}, want, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w;
    int idx;
    tick();
    in_data = 8'hD0; in_valid = 1'b1;
    @(negedge clk);
    tick();
    in_data = 8'hB5;
    for (int k = 1; k <= 2 * NB + 1; k++) begin
      @(negedge clk);
      idx = (k - 1) % NB;
      w   = (k <= NB) ? 8'hD0 : 8'hB5;
      checks++;
      if (k <= 2 * NB) begin
        if ({dout, dout_valid, word_done} !== {exp_bit(w, idx), 1'b1, (idx == NB - 1)}) begin
          errors++;
          $display("FAIL back_to_back cycle %0d {dout,valid,done} got %b want %b",
                   k, {dout, dout_valid, word_done}, {exp_bit(w, idx), 1'b1, (idx == NB - 1)});
        end
      end else if ({dout_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL back_to_back_idle {valid,busy} got %b want 00", {dout_valid, busy});
      end
      if (k == NB) begin
        tick();
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall();
    int idx;
    logic st;
    tick();
    in_data = 8'hD0; in_valid = 1'b1;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= NB + 4; k++) begin
      @(negedge clk);
      if (k < 3)       idx = k - 1;
      else if (k <= 6) idx = 2;
      else             idx = k - 4;
      st = (k >= 3 && k <= 5);
      checks++;
      if (idx < NB) begin
        if ({dout, dout_valid, word_done, in_ready} !==
            {exp_bit(8'hD0, idx), 1'b1, (idx == NB - 1) && !st, (idx == NB - 1) && !st}) begin
          errors++;
          $display("FAIL stall cycle %0d {dout,valid,done,ready} got %b want %b",
                   k, {dout, dout_valid, word_done, in_ready},
                   {exp_bit(8'hD0, idx), 1'b1, (idx == NB - 1) && !st, (idx == NB - 1) && !st});
        end
      end else if ({dout_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL stall_idle {valid,busy} got %b want 00", {dout_valid, busy});
      end
      if (k == 2) begin tick(); stall = 1'b1; end
      if (k == 5) begin tick(); stall = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_word();
    tick();
    in_data = 8'hF8; in_valid = 1'b1;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({dout, dout_valid} !== 2'b11) begin
      errors++;
      $display("FAIL mid_word_bit4 {dout,valid} got %b want 11", {dout, dout_valid});
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dout, dout_valid, word_done, in_ready, busy} !== 5'b00010) begin
      errors++;
      $display("FAIL after_mid_reset {dout,valid,done,ready,busy} got %b want 00010",
               {dout, dout_valid, word_done, in_ready, busy});
    end
    test_single_word(8'hB5);
  endtask

  task automatic test_random();
    int gap, cnt;
    logic hs;
    for (int w = 0; w < 40; w++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        in_valid = 1'b0;
        stall = ($urandom_range(0, 3) == 0);
        tick();
      end
      in_data  = WIDTH'($urandom);
      in_valid = 1'b1;
      cnt = 0;
      hs  = 1'b0;
      while (!hs && cnt < 200) begin
        @(negedge clk);
        hs = in_ready;
        tick();
        stall = ($urandom_range(0, 3) == 0);
        cnt++;
      end
      in_valid = 1'b0;
      checks++;
      if (!hs) begin
        errors++;
        $display("FAIL random_handshake word %0d got no ready want ready within 200 cycles", w);
      end
    end
    stall = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt >= 100 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain busy %b owed %0d want idle with 0 owed", busy, exp_q.size());
    end
  endtask

  task automatic test_detector_stream();
    logic [3:0]  win;
    logic [31:0] mask, want_mask;
    int nbits, sent;
    logic hs;
`ifdef SER_PARITY_EN
    want_mask = 32'h0001_0088;
`else
    want_mask = 32'h0000_8088;
`endif
    win = '0; mask = '0; nbits = 0; sent = 0;
    tick();
    in_data = 8'hDD; in_valid = 1'b1;
    for (int c = 0; c < 4 * NB; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        win = {win[2:0], dout};
        if (nbits >= 3 && win == 4'b1101 && nbits < 32) mask[nbits] = 1'b1;
        nbits++;
      end
      hs = in_valid && in_ready;
      tick();
      if (hs) begin
        sent++;
        if (sent == 1) in_data = 8'h0D;
        else           in_valid = 1'b0;
      end
    end
    checks++;
    if (mask !== want_mask || nbits != 2 * NB) begin
      errors++;
      $display("FAIL detector_1101 hits got %h bits %0d want %h bits %0d", mask, nbits, want_mask, 2 * NB);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word(8'hD0);
    test_single_word(8'hC0);
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_random();
    test_detector_stream();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
